csr_unit: RTL and testbench
===========================

// Module: csr_unit
// PURPOSE
//  Machine-mode CSR file plus interrupt/trap controller for the 3-stage core. Decodes CSR
//  RW/RS/RC ops from the execute stage and arbitrates three interrupt lines. On trap entry
//  it saves PC and cause and redirects fetch; on MRET it restores. Replaces the plain CSR store.
// PARAMETERS
//  DW          32        data width; only DW=32 supported
//  ADDRW       12        CSR address width
//  HART_ID     0         value returned by mhartid (0xF14)
//  RESET_MTVEC 32'h0     mtvec value after reset
// PORTS
//  clk_i          in   1      clock; all state updates on posedge
//  rst_i          in   1      reset, synchronous, active-high
//  csr_addr_i     in   ADDRW  CSR address
//  csr_op_i       in   2      00 none, 01 RW, 10 RS (set), 11 RC (clear)
//  csr_wdata_i    in   DW     write operand / mask
//  csr_rdata_o    out  DW     old CSR value, combinational
//  csr_illegal_o  out  1      op!=00 to unimplemented addr, or RS/RC/RW write to read-only CSR
//  pc_i           in   DW     PC of instruction in execute, saved to mepc on trap
//  stall_i        in   1      pipeline stalled: no trap taken, no CSR write, no mret effect
//  mret_i         in   1      MRET in execute
//  irq_sw_i/irq_tmr_i/irq_ext_i  in 1 each  level interrupt requests (MSI/MTI/MEI)
//  retire_i       in   1      one instruction retired this cycle (counters only)
//  trap_taken_o   out  1      comb: trap accepted this cycle; flush pipeline
//  trap_pc_o      out  DW     comb: handler address, valid with trap_taken_o
//  epc_o          out  DW     current mepc (MRET target)
// BEHAVIOUR
//  Reset: mstatus.MIE=MPIE=0, mie=0, mepc=0, mcause=0, mip=0, mtvec=RESET_MTVEC;
//   outputs: trap_taken_o=0, csr_illegal_o=0 (when op=00), epc_o=0, csr_rdata_o=0.
//  Implemented: mstatus 300 (MIE b3, MPIE b7, MPP[12:11] hardwired 11, rest 0), mie 304
//   (bits 3/7/11 writable), mtvec 305 (mode[1:0]: 00 direct, 01 vectored; bit1 forced 0),
//   mepc 341 (bits[1:0] forced 0), mcause 342, mip 344 (read-only), mhartid F14 (read-only).
//  Read: combinational, returns pre-write value; unimplemented addr -> 0 with illegal=1.
//  Write: posedge; new = RW: wdata, RS: old|wdata, RC: old&~wdata; then WARL masks applied.
//   Illegal ops write nothing. stall_i=1 suppresses writes.
//  mip: irq lines registered once (1-cycle latency) into bits 3/7/11.
//  Take trap when !stall_i && mstatus.MIE && |(mip&mie) && !mret_i.
//   Priority MEI(11) > MSI(3) > MTI(7).
//   trap_pc_o = direct: {mtvec[31:2],2'b00}; vectored: base + 4*cause.
//   Next edge: mepc<=pc_i, mcause<={1'b1,27'b0,cause}, MPIE<=MIE, MIE<=0.
//  MRET (!stall_i): MIE<=MPIE, MPIE<=1; epc_o already holds mepc.
//  Simultaneous: trap beats CSR write (write dropped); MRET beats trap (trap re-evaluated
//   next cycle); CSR write to mstatus.MIE takes effect for trap decision next cycle.
//  rst_i mid-operation: all state back to reset values on that edge; pending irqs discarded.
// CONFIGURATION
//  CSR_COUNTERS_EN defined: 64-bit mcycle (B00/B80, +1 every cycle) and minstret (B02/B82,
//   +1 when retire_i), writable; write wins over increment in same cycle; wrap 2^64-1 -> 0.
//  Undefined: those addresses unimplemented (rdata 0, illegal=1); retire_i ignored.
// STRUCTURE
//  csr_pkg: CSR address localparams, csr_op_e enum, cause codes (3,7,11), mstatus/mie bit
//   positions, WARL masks.
//  Sub-module csr_counter64 (load/inc/wrap), instantiated twice under CSR_COUNTERS_EN.
// TESTING
//  RW mtvec=0x0000_1003 -> readback 0x0000_1001; RC mie 0xFFFF_FFFF -> mie=0.
//  mstatus.MIE=1, mie=0x888, raise irq_ext_i+irq_tmr_i -> 1 cycle later trap, cause 0x8000_000B.
//  mtvec=0x101 vectored, MTI only -> trap_pc_o=0x11C; mepc=pc_i, MIE=0, MPIE=1.
//  mret_i with MPIE=1 -> MIE=1, MPIE=1; irq pending same cycle -> trap next cycle, not this one.
//  op=01 to 0x344 or 0x7C0 -> csr_illegal_o=1, no state change; trap+RW mie same cycle -> mie unchanged.
//  CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF -> wraps to 0 next cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encoding, cause codes and WARL masks
// for the machine-mode CSR unit.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MSIE     = 3;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;

   localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
   localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
   localparam logic [31:0] MEPC_WMASK  = 32'hFFFF_FFFC;

   function automatic logic [31:0] csr_wnew(
      input csr_op_e     op,
      input logic [31:0] old,
      input logic [31:0] wd
   );
      case (op)
         CSR_RW:  return wd;
         CSR_RS:  return old | wd;
         CSR_RC:  return old & ~wd;
         default: return old;
      endcase
   endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access port between execute stage (master) and CSR unit (slave).
interface csr_if #(
   parameter int DW    = 32,
   parameter int ADDRW = 12
);
   logic [ADDRW-1:0] csr_addr_i;
   logic [1:0]       csr_op_i;
   logic [DW-1:0]    csr_wdata_i;
   logic [DW-1:0]    csr_rdata_o;
   logic             csr_illegal_o;

   modport master (
      output csr_addr_i, csr_op_i, csr_wdata_i,
      input  csr_rdata_o, csr_illegal_o
   );

   modport slave (
      input  csr_addr_i, csr_op_i, csr_wdata_i,
      output csr_rdata_o, csr_illegal_o
   );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit performance counter with per-half load; a load in the
// same cycle suppresses the increment.
module csr_counter64 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        i_inc,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [31:0] i_wdata,
   output logic [63:0] o_cnt
);
   logic [63:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (i_wr_lo || i_wr_hi) begin
         r_cnt <= {i_wr_hi ? i_wdata : r_cnt[63:32],
                   i_wr_lo ? i_wdata : r_cnt[31:0]};
      end else if (i_inc) begin
         r_cnt <= r_cnt + 64'd1;
      end
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and interrupt/trap controller.
// Define CSR_COUNTERS_EN to add mcycle/minstret.
module csr_unit
   import csr_pkg::*;
#(
   parameter int          DW          = 32,
   parameter int          ADDRW       = 12,
   parameter int unsigned HART_ID     = 0,
   parameter logic [31:0] RESET_MTVEC = 32'h0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   csr_if.slave          bus,
   input  logic [DW-1:0] pc_i,
   input  logic          stall_i,
   input  logic          mret_i,
   input  logic          irq_sw_i,
   input  logic          irq_tmr_i,
   input  logic          irq_ext_i,
   input  logic          retire_i,
   output logic          trap_taken_o,
   output logic [DW-1:0] trap_pc_o,
   output logic [DW-1:0] epc_o
);
   logic [ADDRW-1:0] w_addr;
   csr_op_e          w_op;
   logic [DW-1:0]    w_old, w_new, w_base, w_pend;
   logic             w_impl, w_ro, w_ill, w_we;
   logic             w_trap, w_mret;
   logic [3:0]       w_cause;

   logic             r_mie_b, r_mpie;
   logic [DW-1:0]    r_mie, r_mtvec, r_mepc, r_mcause, r_mip;

`ifdef CSR_COUNTERS_EN
   logic [63:0] w_mcycle, w_minstret;

   csr_counter64 u_mcycle (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_inc   (1'b1),
      .i_wr_lo (w_we && w_addr == CSR_MCYCLE),
      .i_wr_hi (w_we && w_addr == CSR_MCYCLEH),
      .i_wdata (w_new),
      .o_cnt   (w_mcycle)
   );

   csr_counter64 u_minstret (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_inc   (retire_i),
      .i_wr_lo (w_we && w_addr == CSR_MINSTRET),
      .i_wr_hi (w_we && w_addr == CSR_MINSTRETH),
      .i_wdata (w_new),
      .o_cnt   (w_minstret)
   );
`else
   logic w_unused;
   assign w_unused = retire_i;
`endif

   assign w_addr = bus.csr_addr_i;
   assign w_op   = csr_op_e'(bus.csr_op_i);

   always_comb begin
      w_old  = '0;
      w_impl = 1'b1;
      w_ro   = 1'b0;
      case (w_addr)
         CSR_MSTATUS: begin
            w_old[MSTATUS_MIE]  = r_mie_b;
            w_old[MSTATUS_MPIE] = r_mpie;
            w_old[12:11]        = 2'b11;
         end
         CSR_MIE:     w_old = r_mie;
         CSR_MTVEC:   w_old = r_mtvec;
         CSR_MEPC:    w_old = r_mepc;
         CSR_MCAUSE:  w_old = r_mcause;
         CSR_MIP: begin
            w_old = r_mip;
            w_ro  = 1'b1;
         end
         CSR_MHARTID: begin
            w_old = DW'(HART_ID);
            w_ro  = 1'b1;
         end
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE:    w_old = w_mcycle[31:0];
         CSR_MCYCLEH:   w_old = w_mcycle[63:32];
         CSR_MINSTRET:  w_old = w_minstret[31:0];
         CSR_MINSTRETH: w_old = w_minstret[63:32];
`endif
         default:     w_impl = 1'b0;
      endcase
   end

   assign w_ill = (w_op != CSR_NONE) && (!w_impl || w_ro);
   assign w_new = csr_wnew(w_op, w_old, bus.csr_wdata_i);

   assign bus.csr_rdata_o   = w_old;
   assign bus.csr_illegal_o = w_ill;

   // MEI outranks MSI, which outranks MTI
   assign w_pend = r_mip & r_mie;
   always_comb begin
      if (w_pend[MIE_MEIE])      w_cause = CAUSE_MEI;
      else if (w_pend[MIE_MSIE]) w_cause = CAUSE_MSI;
      else                       w_cause = CAUSE_MTI;
   end

   assign w_mret = mret_i && !stall_i;
   assign w_trap = !stall_i && r_mie_b && (|w_pend) && !mret_i;
   assign w_we   = !stall_i && (w_op != CSR_NONE) && !w_ill && !w_trap;

   assign w_base       = {r_mtvec[DW-1:2], 2'b00};
   assign trap_taken_o = w_trap;
   assign trap_pc_o    = r_mtvec[0] ? w_base + {26'b0, w_cause, 2'b00}
                                    : w_base;
   assign epc_o        = r_mepc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mie_b  <= 1'b0;
         r_mpie   <= 1'b0;
         r_mie    <= '0;
         r_mtvec  <= RESET_MTVEC;
         r_mepc   <= '0;
         r_mcause <= '0;
         r_mip    <= '0;
      end else begin
         r_mip <= '0;
         r_mip[MIE_MSIE] <= irq_sw_i;
         r_mip[MIE_MTIE] <= irq_tmr_i;
         r_mip[MIE_MEIE] <= irq_ext_i;
         if (w_we) begin
            case (w_addr)
               CSR_MSTATUS: begin
                  r_mie_b <= w_new[MSTATUS_MIE];
                  r_mpie  <= w_new[MSTATUS_MPIE];
               end
               CSR_MIE:    r_mie    <= w_new & MIE_WMASK;
               CSR_MTVEC:  r_mtvec  <= w_new & MTVEC_WMASK;
               CSR_MEPC:   r_mepc   <= w_new & MEPC_WMASK;
               CSR_MCAUSE: r_mcause <= w_new;
               default: ;
            endcase
         end
         if (w_trap) begin
            r_mepc   <= pc_i & MEPC_WMASK;
            r_mcause <= {1'b1, 27'b0, w_cause};
            r_mpie   <= r_mie_b;
            r_mie_b  <= 1'b0;
         end
         if (w_mret) begin
            r_mie_b <= r_mpie;
            r_mpie  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit with an expected-value queue.
module tb_csr_unit;
   import csr_pkg::*;

   logic        clk, rst;
   logic [31:0] pc;
   logic        stall, mret, irq_sw, irq_tmr, irq_ext, retire;
   logic        trap_taken;
   logic [31:0] trap_pc, epc;

   int ntests = 0;
   int nfail  = 0;
   logic [31:0] q[$];

   csr_if #(.DW(32), .ADDRW(12)) bus ();

   csr_unit #(
      .DW(32), .ADDRW(12), .HART_ID(0), .RESET_MTVEC(32'h0)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bus          (bus),
      .pc_i         (pc),
      .stall_i      (stall),
      .mret_i       (mret),
      .irq_sw_i     (irq_sw),
      .irq_tmr_i    (irq_tmr),
      .irq_ext_i    (irq_ext),
      .retire_i     (retire),
      .trap_taken_o (trap_taken),
      .trap_pc_o    (trap_pc),
      .epc_o        (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [31:0] v);
      q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      ntests++;
      if (q.size() == 0) begin
         nfail++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      end else begin
         e = q.pop_front();
         assert (obs === e) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic drv(input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] d);
      bus.csr_op_i    = op;
      bus.csr_addr_i  = a;
      bus.csr_wdata_i = d;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pc = '0; stall = 0; mret = 0; retire = 0;
      irq_sw = 0; irq_tmr = 0; irq_ext = 0;
      drv(CSR_NONE, 12'h000, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      push(0); push(0); push(0); push(0);
      #1;
      chk("rst_trap", {31'b0, trap_taken});
      chk("rst_illegal", {31'b0, bus.csr_illegal_o});
      chk("rst_epc", epc);
      chk("rst_rdata", bus.csr_rdata_o);
      drv(CSR_NONE, CSR_MTVEC, 0); push(0); #1;
      chk("rst_mtvec", bus.csr_rdata_o);
      drv(CSR_NONE, CSR_MSTATUS, 0); push(32'h1800); #1;
      chk("rst_mstatus", bus.csr_rdata_o);
      rst = 1'b0;

      tick; drv(CSR_RW, CSR_MTVEC, 32'h1003); push(0); push(0); #1;
      chk("mtvec_old", bus.csr_rdata_o);
      chk("mtvec_legal", {31'b0, bus.csr_illegal_o});
      tick; drv(CSR_NONE, CSR_MTVEC, 0); push(32'h1001); #1;
      chk("mtvec_warl", bus.csr_rdata_o);
      drv(CSR_RW, CSR_MIE, 32'hFFFF_FFFF); push(0); #1;
      chk("mie_old", bus.csr_rdata_o);
      tick; drv(CSR_RC, CSR_MIE, 32'hFFFF_FFFF); push(32'h888); #1;
      chk("mie_warl", bus.csr_rdata_o);
      tick; drv(CSR_NONE, CSR_MIE, 0); push(0); #1;
      chk("mie_rc", bus.csr_rdata_o);

      drv(CSR_RW, CSR_MIP, 32'hFFFF); push(1); #1;
      chk("ill_mip", {31'b0, bus.csr_illegal_o});
      tick; drv(CSR_RW, 12'h7C0, 32'hFFFF); push(1); push(0); #1;
      chk("ill_7c0", {31'b0, bus.csr_illegal_o});
      chk("ill_7c0_rd", bus.csr_rdata_o);
      tick; drv(CSR_NONE, CSR_MIP, 0); push(0); push(0); #1;
      chk("mip_rd", bus.csr_rdata_o);
      chk("mip_rd_legal", {31'b0, bus.csr_illegal_o});
      drv(CSR_RS, CSR_MHARTID, 32'h1); push(1); push(0); #1;
      chk("ill_hartid", {31'b0, bus.csr_illegal_o});
      chk("hartid_rd", bus.csr_rdata_o);

      tick; drv(CSR_RS, CSR_MSTATUS, 32'h8); push(32'h1800); #1;
      chk("mstatus_old", bus.csr_rdata_o);
      tick; drv(CSR_NONE, CSR_MSTATUS, 0); push(32'h1808); #1;
      chk("mstatus_mie", bus.csr_rdata_o);
      drv(CSR_RW, CSR_MIE, 32'h888); #1;
      tick; irq_ext = 1; irq_tmr = 1;
      drv(CSR_NONE, CSR_MIE, 0); push(32'h888); push(0); #1;
      chk("mie_888", bus.csr_rdata_o);
      chk("irq_latency", {31'b0, trap_taken});
      tick; pc = 32'h2000_0042;
      drv(CSR_RW, CSR_MIE, 0); push(1); push(32'h102C); #1;
      chk("trap_mei", {31'b0, trap_taken});
      chk("trap_pc_mei", trap_pc);
      tick; irq_ext = 0; irq_tmr = 0;
      drv(CSR_NONE, CSR_MCAUSE, 0); push(32'h8000_000B); push(32'h2000_0040);
      push(0); #1;
      chk("mcause_mei", bus.csr_rdata_o);
      chk("mepc_mei", epc);
      chk("mie_off_notrap", {31'b0, trap_taken});
      drv(CSR_NONE, CSR_MSTATUS, 0); push(32'h1880); #1;
      chk("mstatus_trap", bus.csr_rdata_o);
      drv(CSR_NONE, CSR_MIE, 0); push(32'h888); #1;
      chk("mie_trap_wdrop", bus.csr_rdata_o);

      tick; irq_tmr = 1;
      drv(CSR_RW, CSR_MTVEC, 32'h101); push(32'h1001); #1;
      chk("mtvec_old2", bus.csr_rdata_o);
      tick; mret = 1;
      drv(CSR_NONE, CSR_MSTATUS, 0); push(0); push(32'h1880); #1;
      chk("mret_mie0", {31'b0, trap_taken});
      chk("mret_pre", bus.csr_rdata_o);
      tick; mret = 0; pc = 32'h300;
      push(1); push(32'h11C); push(32'h1888); #1;
      chk("trap_mti", {31'b0, trap_taken});
      chk("trap_pc_vec", trap_pc);
      chk("mstatus_mret", bus.csr_rdata_o);
      tick; drv(CSR_NONE, CSR_MCAUSE, 0);
      push(32'h8000_0007); push(32'h300); #1;
      chk("mcause_mti", bus.csr_rdata_o);
      chk("mepc_mti", epc);
      mret = 1; drv(CSR_NONE, CSR_MSTATUS, 0);
      push(32'h1880); push(0); #1;
      chk("mstatus_mti", bus.csr_rdata_o);
      chk("mret_notrap_a", {31'b0, trap_taken});
      tick; push(0); push(32'h1888); #1;
      chk("mret_beats_trap", {31'b0, trap_taken});
      chk("mstatus_mret2", bus.csr_rdata_o);
      tick; mret = 0; stall = 1;
      drv(CSR_RW, CSR_MTVEC, 32'h0); push(0); #1;
      chk("stall_notrap", {31'b0, trap_taken});
      tick; stall = 0; pc = 32'h400; irq_sw = 1;
      drv(CSR_NONE, CSR_MTVEC, 0); push(32'h101); push(1); push(32'h11C); #1;
      chk("stall_nowrite", bus.csr_rdata_o);
      chk("trap_after_mret", {31'b0, trap_taken});
      chk("trap_pc_vec2", trap_pc);

      tick; drv(CSR_RS, CSR_MSTATUS, 32'h8); push(32'h400); push(0); #1;
      chk("mepc_400", epc);
      chk("mie_wr_delay", {31'b0, trap_taken});
      tick; drv(CSR_NONE, CSR_MSTATUS, 0); push(1); push(32'h10C); #1;
      chk("trap_msi", {31'b0, trap_taken});
      chk("trap_pc_msi", trap_pc);

      rst = 1;
      tick; rst = 0;
      drv(CSR_NONE, CSR_MIE, 0); push(0); push(0); push(0); #1;
      chk("rst2_epc", epc);
      chk("rst2_trap", {31'b0, trap_taken});
      chk("rst2_mie", bus.csr_rdata_o);
      drv(CSR_NONE, CSR_MTVEC, 0); push(0); #1;
      chk("rst2_mtvec", bus.csr_rdata_o);
      drv(CSR_NONE, CSR_MSTATUS, 0); push(32'h1800); #1;
      chk("rst2_mstatus", bus.csr_rdata_o);
      irq_sw = 0; irq_tmr = 0;

`ifdef CSR_COUNTERS_EN
      tick; drv(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF); #1;
      tick; drv(CSR_RW, CSR_MCYCLEH, 32'hFFFF_FFFF); #1;
      tick; drv(CSR_NONE, CSR_MCYCLE, 0); push(32'hFFFF_FFFF); #1;
      chk("mcycle_lo_max", bus.csr_rdata_o);
      drv(CSR_NONE, CSR_MCYCLEH, 0); push(32'hFFFF_FFFF); #1;
      chk("mcycle_hi_max", bus.csr_rdata_o);
      tick; drv(CSR_NONE, CSR_MCYCLE, 0); push(0); #1;
      chk("mcycle_lo_wrap", bus.csr_rdata_o);
      drv(CSR_NONE, CSR_MCYCLEH, 0); push(0); #1;
      chk("mcycle_hi_wrap", bus.csr_rdata_o);
      tick; retire = 1; drv(CSR_RW, CSR_MINSTRET, 32'h5); #1;
      tick; drv(CSR_NONE, CSR_MINSTRET, 0); push(32'h5); #1;
      chk("minstret_wr_wins", bus.csr_rdata_o);
      tick; retire = 0; push(32'h6); #1;
      chk("minstret_inc", bus.csr_rdata_o);
`else
      tick; drv(CSR_RW, CSR_MCYCLE, 32'h1); push(1); push(0); #1;
      chk("ill_mcycle", {31'b0, bus.csr_illegal_o});
      chk("mcycle_rd0", bus.csr_rdata_o);
      retire = 1;
      drv(CSR_RS, CSR_MINSTRETH, 32'h1); push(1); push(0); #1;
      chk("ill_minstreth", {31'b0, bus.csr_illegal_o});
      chk("minstreth_rd0", bus.csr_rdata_o);
      retire = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
